// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_IMMEX   = 4'd8,
    ST_IMMWB   = 4'd9,
    ST_BEQEX   = 4'd10,
    ST_BNEEX   = 4'd11,
    ST_JEX     = 4'd12
  } state_t;

  // Which rule the ALU decoder applies in the current state
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADDR,
    CLS_RTYPE,
    CLS_IMM,
    CLS_BRANCH
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;
  localparam logic [1:0] SRCA_B  = 2'b10;

  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SIMM     = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZIMM     = 3'b100;
  localparam logic [2:0] SRCB_SHAMT    = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multi_control_alu_decoder.sv
// ALU operation decode from state class, opcode and funct; also flags
// R-type shifts, which take rt/shamt instead of rs/rt as operands.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_t   alu_cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       shift_sel
);

  always_comb begin
    alu_control = ALU_AND;
    shift_sel   = 1'b0;
    case (alu_cls)
      CLS_ADDR:   alu_control = ALU_ADD;
      CLS_BRANCH: alu_control = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD: alu_control = ALU_ADD;
          FN_SUB: alu_control = ALU_SUB;
          FN_AND: alu_control = ALU_AND;
          FN_OR:  alu_control = ALU_OR;
          FN_SLT: alu_control = ALU_SLT;
          FN_SLL: begin alu_control = ALU_SLL; shift_sel = 1'b1; end
          FN_SRL: begin alu_control = ALU_SRL; shift_sel = 1'b1; end
          FN_SRA: begin alu_control = ALU_SRA; shift_sel = 1'b1; end
          default: alu_control = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (opcode)
          OP_SLTI: alu_control = ALU_SLT;
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multi_control.sv
// Moore main controller for the multi-cycle MIPS datapath.
//
//   state    | meaning
//   FETCH    | read instr at PC into IR, PC <= PC + 4
//   DECODE   | read regs, branch target into ALUOut
//   MEMADR   | lw/sw effective address
//   MEMRD    | data memory read
//   MEMWB    | load data into rt
//   MEMWR    | data memory write
//   RTYPEEX  | R-type ALU op
//   RTYPEWB  | R-type result into rd
//   IMMEX    | immediate ALU op
//   IMMWB    | immediate result into rt
//   BEQEX    | compare, take branch on zero
//   BNEEX    | compare, take branch on non-zero
//   JEX      | jump
module mips_multi_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pc_en_o,
  output logic       i_or_d_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [2:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_control_o
);

  state_t   state, state_nxt;
  alu_cls_t alu_cls;
  logic     shift_sel;
  logic     pc_en, mem_write, ir_write, reg_write;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:                        state_nxt = ST_MEMADR;
          OP_RTYPE:                            state_nxt = ST_RTYPEEX;
          OP_BEQ:                              state_nxt = ST_BEQEX;
          OP_BNE:                              state_nxt = ST_BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state_nxt = ST_IMMEX;
          OP_J:                                state_nxt = ST_JEX;
          default:                             state_nxt = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_nxt = (opcode_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   state_nxt = ST_MEMWB;
      ST_RTYPEEX: state_nxt = ST_RTYPEWB;
      ST_IMMEX:   state_nxt = ST_IMMWB;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_cls     (alu_cls),
    .opcode      (opcode_i),
    .funct       (funct_i),
    .alu_control (alu_control_o),
    .shift_sel   (shift_sel)
  );

  always_comb begin
    pc_en        = 1'b0;
    i_or_d_o     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write    = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_B;
    pc_src_o     = PCSRC_ALU;
    alu_cls      = CLS_NONE;
    case (state)
      ST_FETCH: begin
        ir_write    = 1'b1;
        pc_en       = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_cls     = CLS_ADDR;
      end
      ST_DECODE: begin
        alu_src_b_o = SRCB_SIMM_SH2;
        alu_cls     = CLS_ADDR;
      end
      ST_MEMADR: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_SIMM;
        alu_cls     = CLS_ADDR;
      end
      ST_MEMRD: i_or_d_o = 1'b1;
      ST_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write    = 1'b1;
      end
      ST_MEMWR: begin
        i_or_d_o  = 1'b1;
        mem_write = 1'b1;
      end
      ST_RTYPEEX: begin
        alu_cls     = CLS_RTYPE;
        alu_src_a_o = shift_sel ? SRCA_B : SRCA_A;
        alu_src_b_o = shift_sel ? SRCB_SHAMT : SRCB_B;
      end
      ST_RTYPEWB: begin
        reg_dst_o = 1'b1;
        reg_write = 1'b1;
      end
      ST_IMMEX: begin
        alu_cls     = CLS_IMM;
        alu_src_a_o = SRCA_A;
        alu_src_b_o = (opcode_i == OP_ANDI || opcode_i == OP_ORI) ? SRCB_ZIMM : SRCB_SIMM;
      end
      ST_IMMWB: reg_write = 1'b1;
      ST_BEQEX, ST_BNEEX: begin
        alu_cls     = CLS_BRANCH;
        alu_src_a_o = SRCA_A;
        pc_src_o    = PCSRC_ALUOUT;
        pc_en       = (state == ST_BEQEX) ? zero_i : !zero_i;
      end
      ST_JEX: begin
        pc_src_o = PCSRC_JUMP;
        pc_en    = 1'b1;
      end
      default: alu_cls = CLS_NONE;
    endcase
  end

  // Reset holds FETCH mux values but must not let any write enable through
  assign pc_en_o     = pc_en & ~reset_i;
  assign ir_write_o  = ir_write & ~reset_i;
  assign mem_write_o = mem_write & ~reset_i;
  assign reg_write_o = reg_write & ~reset_i;

endmodule

// File: tb/tb_mips_multi_control.sv
// Randomized scoreboard bench for mips_multi_control: an instruction-level
// model expands each instruction into its cycle schedule and predicts outputs.
module tb_mips_multi_control;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] opcode_i = 6'd0;
  logic [5:0] funct_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       pc_en_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o;
  logic       mem_to_reg_o, reg_write_o;
  logic [1:0] alu_src_a_o, pc_src_o;
  logic [2:0] alu_src_b_o, alu_control_o;

  mips_multi_control dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .opcode_i      (opcode_i),
    .funct_i       (funct_i),
    .zero_i        (zero_i),
    .pc_en_o       (pc_en_o),
    .i_or_d_o      (i_or_d_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .pc_src_o      (pc_src_o),
    .alu_control_o (alu_control_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle kinds of the instruction schedules
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_RX = 6, P_RWB = 7, P_IX = 8, P_IWB = 9, P_BEQ = 10, P_BNE = 11, P_J = 12;

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] exp_q[$];
  int          ph_q[$];
  bit          drv_done = 1'b0;

  // {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
  //  src_a[1:0], src_b[2:0], pc_src[1:0], alu[2:0]}
  function automatic logic [16:0] model(input int ph, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z,
                                        input logic rst);
    logic pe, iod, mw, irw, rd, m2r, rw;
    logic [1:0] sa, ps;
    logic [2:0] sb, alu;
    pe = 0; iod = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0;
    sa = 2'b00; sb = 3'b000; ps = 2'b00; alu = 3'b000;
    case (ph)
      P_F:   begin irw = 1; pe = 1; sb = 3'b001; alu = 3'b010; end
      P_D:   begin sb = 3'b011; alu = 3'b010; end
      P_MA:  begin sa = 2'b01; sb = 3'b010; alu = 3'b010; end
      P_MR:  iod = 1;
      P_MWB: begin m2r = 1; rw = 1; end
      P_MW:  begin iod = 1; mw = 1; end
      P_RX: begin
        sa = 2'b01; sb = 3'b000;
        if      (fn == 6'b100000) alu = 3'b010;
        else if (fn == 6'b100010) alu = 3'b110;
        else if (fn == 6'b100100) alu = 3'b000;
        else if (fn == 6'b100101) alu = 3'b001;
        else if (fn == 6'b101010) alu = 3'b111;
        else if (fn == 6'b000000) begin alu = 3'b011; sa = 2'b10; sb = 3'b101; end
        else if (fn == 6'b000010) begin alu = 3'b100; sa = 2'b10; sb = 3'b101; end
        else if (fn == 6'b000011) begin alu = 3'b101; sa = 2'b10; sb = 3'b101; end
        else alu = 3'b010;
      end
      P_RWB: begin rd = 1; rw = 1; end
      P_IX: begin
        sa = 2'b01;
        if      (op == 6'b001000) begin sb = 3'b010; alu = 3'b010; end
        else if (op == 6'b001010) begin sb = 3'b010; alu = 3'b111; end
        else if (op == 6'b001100) begin sb = 3'b100; alu = 3'b000; end
        else                      begin sb = 3'b100; alu = 3'b001; end
      end
      P_IWB: rw = 1;
      P_BEQ: begin sa = 2'b01; alu = 3'b110; ps = 2'b01; pe = z; end
      P_BNE: begin sa = 2'b01; alu = 3'b110; ps = 2'b01; pe = !z; end
      P_J:   begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    if (rst) begin pe = 0; irw = 0; mw = 0; rw = 0; end
    return {pe, iod, mw, irw, rd, m2r, rw, sa, sb, ps, alu};
  endfunction

  function automatic logic [16:0] actual();
    return {pc_en_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
            reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_control_o};
  endfunction

  task automatic step(input int ph, input logic [5:0] op, input logic [5:0] fn,
                      input logic rst);
    logic z;
    @(posedge clk_i);
    #1;
    z = 1'($urandom);
    reset_i  = rst;
    opcode_i = op;
    funct_i  = fn;
    zero_i   = z;
    exp_q.push_back(model(ph, op, fn, z, rst));
    ph_q.push_back(ph);
  endtask

  task automatic do_abort(input logic [5:0] op, input logic [5:0] fn);
    logic [16:0] e;
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    e = model(P_F, op, fn, 1'b0, 1'b1);
    vectors++;
    if (actual() !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", actual(), e);
    end
    step(P_F, op, fn, 1'b1);
    step(P_F, op, fn, 1'b1);
  endtask

  // abort_at: index in the cycle schedule after which reset is asserted; -1 none
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    int seq[$];
    seq = {P_F, P_D};
    case (op)
      6'b100011: begin seq.push_back(P_MA); seq.push_back(P_MR); seq.push_back(P_MWB); end
      6'b101011: begin seq.push_back(P_MA); seq.push_back(P_MW); end
      6'b000000: begin seq.push_back(P_RX); seq.push_back(P_RWB); end
      6'b000100: seq.push_back(P_BEQ);
      6'b000101: seq.push_back(P_BNE);
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        seq.push_back(P_IX); seq.push_back(P_IWB);
      end
      6'b000010: seq.push_back(P_J);
      default: ;
    endcase
    foreach (seq[i]) begin
      step(seq[i], op, fn, 1'b0);
      if (i == abort_at) begin
        do_abort(op, fn);
        return;
      end
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle
  initial begin
    logic [16:0] e;
    int ph;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ph = ph_q.pop_front();
        vectors++;
        if (actual() !== e) begin
          miscompares++;
          $display("FAIL cycle_ph%0d op=%b fn=%b: got %b want %b",
                   ph, opcode_i, funct_i, actual(), e);
        end
      end
    end
  end

  logic [5:0] op_tab[10];
  logic [5:0] fn_tab[8];

  initial begin
    logic [5:0] op, fn;
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
               6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b000000, 6'b000010, 6'b000011};
    step(P_F, 6'd0, 6'd0, 1'b1);
    step(P_F, 6'd0, 6'd0, 1'b1);
    // Directed: lw aborted in MEMRD, then the plan's named cases
    run_instr(6'b100011, 6'd0, 3);
    run_instr(6'b100011, 6'd0, -1);
    run_instr(6'b101011, 6'd0, -1);
    run_instr(6'b000000, 6'b100010, -1);
    run_instr(6'b000000, 6'b000011, -1);
    run_instr(6'b000100, 6'd0, -1);
    run_instr(6'b000101, 6'd0, -1);
    run_instr(6'b001100, 6'd0, -1);
    run_instr(6'b001010, 6'd0, -1);
    run_instr(6'b001000, 6'd0, -1);
    run_instr(6'b111111, 6'd0, -1);
    run_instr(6'b000010, 6'd0, -1);
    for (int n = 0; n < 400; n++) begin
      int k;
      k  = $urandom_range(0, 11);
      op = (k < 10) ? op_tab[k] : 6'($urandom);
      k  = $urandom_range(0, 9);
      fn = (k < 8) ? fn_tab[k] : 6'($urandom);
      run_instr(op, fn, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 20000) begin
      @(posedge clk_i);
      budget++;
    end
    if (!drv_done) begin
      vectors++;
      miscompares++;
      $display("FAIL driver_timeout: got %0d cycles want completion", budget);
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk_i);
      budget++;
    end
    @(posedge clk_i);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multi_control.md
# mips_multi_control

Multi-cycle main controller for the 32-bit MIPS core, sitting directly upstream of the ALU. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the datapath mux selects, write enables and the 3-bit ALU operation. It also consumes the ALU `zero` flag to resolve branches.

## Interface
- Parameters: none (opcode, funct and ALU-op encodings are fixed constants in the shared package)
- `clk_i` in 1: single clock, rising edge
- `reset_i` in 1: asynchronous, active-high; state forced to FETCH
- `opcode_i` in 6: instr[31:26] from instruction register
- `funct_i` in 6: instr[5:0] from instruction register
- `zero_i` in 1: ALU zero flag, same cycle
- `pc_en_o` out 1: PC register load enable
- `i_or_d_o` out 1: memory address select; 0 = PC, 1 = ALUOut
- `mem_write_o` out 1: data memory write strobe
- `ir_write_o` out 1: instruction register load
- `reg_dst_o` out 1: write register select; 0 = rt, 1 = rd
- `mem_to_reg_o` out 1: writeback data select; 0 = ALUOut, 1 = memory data register
- `reg_write_o` out 1: register file write enable
- `alu_src_a_o` out 2: ALU A select; 00 = PC, 01 = A reg (rs), 10 = B reg (rt)
- `alu_src_b_o` out 3: ALU B select; 000 = B reg, 001 = const 4, 010 = sign-extended imm, 011 = sign-extended imm<<2, 100 = zero-extended imm, 101 = shamt
- `pc_src_o` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], instr[25:0], 2'b00}
- `alu_control_o` out 3: ALU op; 000 and, 001 or, 010 add, 011 sll, 100 srl, 101 sra, 110 sub, 111 slt

## Operation
- States and transitions:
  - FETCH → DECODE
  - DECODE, by opcode:
    - lw/sw (100011/101011) → MEMADR
    - R-type (000000) → RTYPEEX
    - beq (000100) → BEQEX
    - bne (000101) → BNEEX
    - addi/slti/andi/ori (001000/001010/001100/001101) → IMMEX
    - j (000010) → JEX
    - any other opcode → FETCH (executes as nop)
  - MEMADR → MEMRD if lw, MEMWR if sw; MEMRD → MEMWB → FETCH; MEMWR → FETCH
  - RTYPEEX → RTYPEWB → FETCH; IMMEX → IMMWB → FETCH; BEQEX/BNEEX/JEX → FETCH
- Outputs are a pure function of state, opcode and funct. `pc_en_o` additionally depends on `zero_i`. All unlisted outputs are 0 in every state.
- Per-state outputs:
  - FETCH: `i_or_d_o`=0, `ir_write_o`=1, src_a=00, src_b=001, op=add, `pc_src_o`=00, `pc_en_o`=1
  - DECODE: src_a=00, src_b=011, op=add (branch target into ALUOut)
  - MEMADR: src_a=01, src_b=010, op=add
  - MEMRD: `i_or_d_o`=1
  - MEMWB: `reg_dst_o`=0, `mem_to_reg_o`=1, `reg_write_o`=1
  - MEMWR: `i_or_d_o`=1, `mem_write_o`=1
  - RTYPEEX: op from funct decode
    - add 100000, sub 100010, and 100100, or 100101, slt 101010: src_a=01, src_b=000
    - sll 000000, srl 000010, sra 000011: src_a=10, src_b=101
    - unknown funct: op=add, src_a=01, src_b=000
  - RTYPEWB: `reg_dst_o`=1, `reg_write_o`=1
  - IMMEX: src_a=01
    - addi: src_b=010, op=add
    - slti: src_b=010, op=slt
    - andi: src_b=100, op=and
    - ori: src_b=100, op=or
  - IMMWB: `reg_dst_o`=0, `reg_write_o`=1
  - BEQEX: src_a=01, src_b=000, op=sub, `pc_src_o`=01, `pc_en_o`=`zero_i`
  - BNEEX: same as BEQEX, but `pc_en_o`=!`zero_i`
  - JEX: `pc_src_o`=10, `pc_en_o`=1
- Opcode and funct are only meaningful after FETCH has loaded the IR. The block relies on the IR being stable from DECODE through writeback, since `ir_write_o` is high only in FETCH.

## Timing
- One state transition per rising edge.
- Cycles per instruction, FETCH inclusive: lw 5; sw 4; R-type 4; immediate ops 4; beq/bne 3; j 3; unknown opcode 2.
- Reset:
  - Asserting `reset_i` sets state to FETCH immediately, without waiting for a clock edge.
  - While `reset_i` is high, `pc_en_o`, `ir_write_o`, `mem_write_o` and `reg_write_o` are forced to 0. The mux selects and `alu_control_o` show FETCH values: src_a=00, src_b=001, op=010, `i_or_d_o`=0, `pc_src_o`=00.
  - After `reset_i` deasserts, the first clock edge completes the FETCH cycle.
- Reset mid-instruction abandons the instruction. No write enable may pulse during or after the reset edge until FETCH.
- `zero_i` is combinational from the ALU within the BEQEX/BNEEX cycle. `pc_en_o` is therefore combinational from `zero_i` in those states only.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (`logic [3:0]`, 13 states, FETCH = 0)
  - opcode and funct localparams
  - ALU-op localparams (AND..SLT matching the 3-bit encoding above)
  - alu_src_a, alu_src_b and pc_src select localparams
- One sub-module: `alu_decoder`, combinational. It maps state class (mem/R-type/imm/branch), opcode and funct to `alu_control_o` and the shift-select flag.
- The top holds the state register and next-state/output logic.

## Test plan
- Reset mid-instruction: assert `reset_i` during MEMRD of a lw → state FETCH; `reg_write_o` never high; `ir_write_o`=0 until release; after release FETCH outputs `pc_en_o`=1, op=010.
- lw then sw: opcode 100011 → state trace FETCH, DECODE, MEMADR, MEMRD, MEMWB with `reg_write_o`=1 and `mem_to_reg_o`=1 in MEMWB only; opcode 101011 → `mem_write_o`=1 for exactly one cycle.
- R-type: funct 100010 → RTYPEEX op=110, src_b=000; funct 000011 → op=101, src_a=10, src_b=101; RTYPEWB `reg_dst_o`=1.
- Branch: beq with `zero_i`=1 → `pc_en_o`=1, `pc_src_o`=01; `zero_i`=0 → `pc_en_o`=0; bne inverts both results; next state FETCH.
- Immediate ops: andi → op=000, src_b=100; slti → op=111, src_b=010; addi → 4 cycles with `reg_write_o` in IMMWB.
- Illegal opcode 111111 → DECODE → FETCH; no write enable asserted; j 000010 → JEX with `pc_src_o`=10, `pc_en_o`=1.
